segment_display_scanner: RTL
============================

# segment_display_scanner

Time-multiplexed controller for an N-digit common-anode 7-segment display. It latches a hex value, then cycles through the digits, one at a time. For each digit it routes one nibble through the existing hex-to-segment decoder (`ConvertSegmentDisplay`), drives the matching anode, and inserts an all-off gap between digits to suppress ghosting. It sits between the debug/status datapath (register or stack-top readout) and the board's display pins.

## Interface
Parameters:
- `N_DIGITS`, 4: number of digits. Legal range 1..8.
- `DIV_CYCLES`, 50000: clocks each digit is driven. Must be ≥ 1.
- `GAP_CYCLES`, 500: clocks all anodes are off between digits. 0 is legal and means no gap.

Ports:
- `i_CLK`, in, 1: the only clock. All logic is on the rising edge.
- `i_RST`, in, 1: reset, synchronous, active-high.
- `i_ENABLE`, in, 1: scanning enabled. When low, the display is dark.
- `i_LOAD`, in, 1: one-cycle strobe that captures `i_VALUE`, `i_DP` and `i_LZS` into the pending registers.
- `i_VALUE`, in, 4*N_DIGITS: hex value. Nibble k drives digit k; digit 0 is the rightmost.
- `i_DP`, in, N_DIGITS: decimal point request per digit, active-high.
- `i_LZS`, in, 1: leading-zero suppression request.
- `o_SEG`, out, 7: segments in .GFEDCBA order, active-low.
- `o_DP_N`, out, 1: decimal point, active-low.
- `o_AN`, out, N_DIGITS: digit anodes, active-low, one-hot-low or all ones.
- `o_DIGIT`, out, 3: index of the digit being driven. Holds its last value during the gap.
- `o_FRAME`, out, 1: one-cycle pulse when digit 0 starts and the new frame is committed.

## Operation
- Two register banks:
  - Pending bank: value, dp, lzs. Written on any cycle where `i_LOAD` = 1.
  - Display bank: copied from the pending bank only at a frame boundary. A single frame therefore never mixes old and new nibbles.
- FSM states and transitions:
  - IDLE: all anodes off. When `i_ENABLE` = 1, commit the pending bank, set digit := 0, go to DRIVE, and pulse `o_FRAME`.
  - DRIVE: `o_AN[digit]` = 0, `o_SEG` = decode(nibble[digit]), `o_DP_N` = ~dp[digit]. Count `DIV_CYCLES` clocks, then go to GAP. If `GAP_CYCLES` = 0, advance directly as if leaving GAP.
  - GAP: `o_AN` all 1, `o_SEG` = 7'h7F, `o_DP_N` = 1. Count `GAP_CYCLES` clocks, then advance:
    - digit < N_DIGITS-1: digit := digit+1, go to DRIVE.
    - otherwise: wrap digit := 0, commit the pending bank, pulse `o_FRAME`, go to DRIVE.
  - Any state: `i_ENABLE` = 0 forces IDLE on the next edge. The display is dark from that edge and the counters clear.
- Leading-zero suppression (when display lzs = 1):
  - Digit k is blanked if it and every higher digit are 0. Blanked means its anode is still driven, with `o_SEG` = 7'h7F.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - A dp bit forces its own digit and all lower digits to stay unblanked.
- Decode table is fixed: 0..9, A, b, C, d, E, F, as provided by `ConvertSegmentDisplay`.
- If `i_LOAD` arrives in the same cycle as a commit, the new `i_VALUE` is written to pending and also committed; the commit uses the load-bypass data.

## Timing
- Reset values: state IDLE; `o_AN` = all 1; `o_SEG` = 7'h7F; `o_DP_N` = 1; `o_DIGIT` = 0; `o_FRAME` = 0; both banks = 0; counters = 0.
- All outputs are registered, and `o_AN`, `o_SEG` and `o_DP_N` change on the same edge, so there is no segment glitch on an active anode.
- `i_ENABLE` rising with the FSM in IDLE: the first anode is low 1 cycle later.
- Digit period is `DIV_CYCLES` + `GAP_CYCLES`.
- Frame period is N_DIGITS × (`DIV_CYCLES` + `GAP_CYCLES`).
- `o_FRAME` pulse spacing equals the frame period.
- `i_LOAD` to visible change: from 1 cycle (load on a commit edge) up to 1 frame period plus 1 cycle.
- `i_RST` asserted mid-DRIVE: outputs reach their reset values on the next edge. The pending load is discarded.

## Structure
- Shared package `segment_display_pkg`:
  - FSM state enum {IDLE, DRIVE, GAP}.
  - Constants `SEG_BLANK` = 7'h7F and `AN_OFF` (all ones).
  - Width function for the digit counter, clog2 of N_DIGITS with a minimum of 1.
- One sub-module instance: `ConvertSegmentDisplay`, fed with the nibble muxed by next-digit index. Its output is captured into the `o_SEG` register.
- Counter width is clog2(max(`DIV_CYCLES`, `GAP_CYCLES`)).

## Test plan
Benches use N_DIGITS = 4, DIV_CYCLES = 4, GAP_CYCLES = 1 unless stated.
- Reset, then `i_ENABLE` = 1 with pending value 16'h0000 → 1 cycle later `o_AN` = 4'b1110 and `o_SEG` = 7'h40. `o_AN` = 4'b1101 appears 5 cycles later. `o_FRAME` pulses every 20 cycles.
- Load 16'hA3F1 mid-frame → the old value persists until the next `o_FRAME` edge. Then the digits show 7'h79 (1), 7'h0E (F), 7'h30 (3) and 7'h08 (A), in digit order 0..3.
- Load 16'h0042 with lzs = 1 → digits 3 and 2 show 7'h7F with their anodes low. dp = 4'b0100 unblanks digit 2 (7'h40, `o_DP_N` = 0).
- `GAP_CYCLES` = 0 → one-hot-low `o_AN` steps with no all-1 cycle, and the period is 16 cycles.
- Drop `i_ENABLE` mid-DRIVE → `o_AN` = 4'hF on the next edge. On re-enable, scanning restarts at digit 0 with an `o_FRAME` pulse.
- Assert `i_RST` during GAP with a load pending → all outputs are at their reset values on the next edge. After re-enable the display shows 16'h0000.

Source files
------------

// File: rtl/segment_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package segment_display_pkg;

    // Scanner FSM states
    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } state_e;

    // All segments off (active-low) and all anodes off (active-low, sliced to width by users)
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Bits needed to index 0..n-1, never less than one bit
    function automatic int unsigned digit_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ConvertSegmentDisplay.sv
// Hex nibble to active-low 7-segment pattern, bit order .GFEDCBA.
module ConvertSegmentDisplay (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Fixed glyph table: 0-9, A, b, C, d, E, F
    always_comb begin
        seg_o = 7'h7F;
        case (nibble_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/segment_display_scanner.sv
// Time-multiplexed scanner for an N-digit common-anode 7-segment display.
// A pending bank is loaded at any time; the display bank only follows it at a
// frame boundary so a single frame never mixes old and new digits.
module segment_display_scanner
    import segment_display_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned DIV_CYCLES = 50000,
    parameter int unsigned GAP_CYCLES = 500
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_ENABLE,
    input  logic                  i_LOAD,
    input  logic [4*N_DIGITS-1:0] i_VALUE,
    input  logic [N_DIGITS-1:0]   i_DP,
    input  logic                  i_LZS,
    output logic [6:0]            o_SEG,
    output logic                  o_DP_N,
    output logic [N_DIGITS-1:0]   o_AN,
    output logic [2:0]            o_DIGIT,
    output logic                  o_FRAME
);

    localparam int unsigned DW      = digit_width(N_DIGITS);
    localparam int unsigned CNT_MAX = (DIV_CYCLES > GAP_CYCLES) ? DIV_CYCLES : GAP_CYCLES;
    localparam int unsigned CW      = digit_width(CNT_MAX);
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(N_DIGITS - 1);

    state_e                state_q, state_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  commit, advance;

    logic [4*N_DIGITS-1:0] pend_val_q, disp_val_q, disp_val_d;
    logic [N_DIGITS-1:0]   pend_dp_q, disp_dp_q, disp_dp_d;
    logic                  pend_lzs_q, disp_lzs_q, disp_lzs_d;

    logic [N_DIGITS-1:0]   blank_d;
    logic [3:0]            nib_d;
    logic [6:0]            dec_seg;
    logic [N_DIGITS-1:0]   an_d;
    logic [6:0]            seg_d;
    logic                  dp_n_d;
    logic [2:0]            digit_ext;

    // Next-state logic: digit/gap timing and frame-boundary commit
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_ENABLE) begin
                    state_d = DRIVE;
                    digit_d = '0;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (GAP_CYCLES == 0) advance = 1'b1;
                    else                 state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (advance) begin
            state_d = DRIVE;
            if (digit_q == LAST_DIGIT) begin
                digit_d = '0;
                commit  = 1'b1;
            end else begin
                digit_d = digit_q + DW'(1);
            end
        end
        // Disable wins over everything: go dark and clear counters
        if (!i_ENABLE) begin
            state_d = IDLE;
            digit_d = '0;
            cnt_d   = '0;
            commit  = 1'b0;
        end
    end

    // Display bank as it will be after this edge; a same-cycle load bypasses pending
    always_comb begin
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        disp_lzs_d = disp_lzs_q;
        if (commit) begin
            disp_val_d = i_LOAD ? i_VALUE : pend_val_q;
            disp_dp_d  = i_LOAD ? i_DP    : pend_dp_q;
            disp_lzs_d = i_LOAD ? i_LZS   : pend_lzs_q;
        end
    end

    // Leading-zero blanking: a digit blanks only if it and all higher digits are zero
    // with no decimal point among them; digit 0 always shows
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank_d    = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (disp_val_d[4*k +: 4] == 4'h0) & ~disp_dp_d[k];
            blank_d[k] = disp_lzs_d & (k != 0) & upper_zero;
        end
    end

    assign nib_d = disp_val_d[{digit_d, 2'b00} +: 4];

    ConvertSegmentDisplay u_convert (
        .nibble_i (nib_d),
        .seg_o    (dec_seg)
    );

    // Pin values for the next state, so anode/segment/dp all update on one edge
    always_comb begin
        an_d      = AN_OFF[N_DIGITS-1:0];
        seg_d     = SEG_BLANK;
        dp_n_d    = 1'b1;
        digit_ext = '0;
        digit_ext[DW-1:0] = digit_d;
        if (state_d == DRIVE) begin
            an_d[digit_d] = 1'b0;
            seg_d         = blank_d[digit_d] ? SEG_BLANK : dec_seg;
            dp_n_d        = ~disp_dp_d[digit_d];
        end
    end

    // FSM, display bank and registered outputs
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q    <= IDLE;
            digit_q    <= '0;
            cnt_q      <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            disp_lzs_q <= 1'b0;
            o_AN       <= AN_OFF[N_DIGITS-1:0];
            o_SEG      <= SEG_BLANK;
            o_DP_N     <= 1'b1;
            o_DIGIT    <= '0;
            o_FRAME    <= 1'b0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            cnt_q      <= cnt_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            disp_lzs_q <= disp_lzs_d;
            o_AN       <= an_d;
            o_SEG      <= seg_d;
            o_DP_N     <= dp_n_d;
            o_DIGIT    <= digit_ext;
            o_FRAME    <= commit;
        end
    end

    // Pending bank: captures every load strobe
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_lzs_q <= 1'b0;
        end else if (i_LOAD) begin
            pend_val_q <= i_VALUE;
            pend_dp_q  <= i_DP;
            pend_lzs_q <= i_LZS;
        end
    end

endmodule
